motoro3_pwm_capture: RTL and testbench
======================================

Name: motoro3_pwm_capture

Overview:
Receive-side counterpart of the motor PWM generator: it measures a PWM waveform (gate-drive loopback or external PWM command) in clk cycles.
- Reports the latest on-time and off-time pair with a one-cycle valid strobe.
- Flags constant-high or constant-low input.
- Sits beside the 3-phase commutation logic and is gated by the phase enables aE/bE/cE.

Parameters:
CNT_W, 13, width of the period counters and the onTime/offTime outputs
STUCK_CYC, 13'd8000, cycles without an edge before a stuck flag is raised (800 us at 10 MHz); must be less than 2^CNT_W, so counters never saturate
DGL_N, 4, deglitch length in cycles (used only with the optional feature)

Ports:
clk  input  1  system clock, 10 MHz
nRst  input  1  asynchronous active-low reset
pwmIn  input  1  PWM under measurement, asynchronous to clk
aE  input  1  phase A enable
bE  input  1  phase B enable
cE  input  1  phase C enable
onTime  output  CNT_W  last captured high duration, in cycles
offTime  output  CNT_W  last captured low duration, in cycles
capValid  output  1  one-cycle pulse when onTime/offTime update
stuckHi  output  1  level; input has been high for STUCK_CYC cycles
stuckLo  output  1  level; input has been low for STUCK_CYC cycles

Behaviour:
- Clocking and reset: single clock, posedge clk; reset is asynchronous, active-low on nRst.
- Reset values: onTime=0, offTime=0, capValid=0, stuckHi=0, stuckLo=0, state=IDLE, cnt=0, sync flops=0.
- Synchronizer: two-flop synchronizer on pwmIn gives pwmS; pwmD is pwmS delayed one cycle.
  - rise = pwmS & ~pwmD; fall = ~pwmS & pwmD.
  - Edge-detect latency is 3 clk cycles after the pwmIn transition.
- en = aE | bE | cE. When en=0, it overrides every state: next cycle state=IDLE, cnt=0, onTime/offTime/stuck flags=0, capValid=0.
- Internal: cnt (CNT_W bits), hiLatch (CNT_W bits).
- IDLE:
  - cnt increments each cycle.
  - rise -> HIGH, cnt<=1. fall is ignored (cnt keeps counting).
  - cnt==STUCK_CYC with no edge -> STUCK; stuckHi<=pwmS, stuckLo<=~pwmS.
- HIGH:
  - cnt increments.
  - fall -> hiLatch<=cnt, cnt<=1, go LOW.
  - cnt==STUCK_CYC with no fall -> STUCK, stuckHi<=1.
- LOW:
  - cnt increments.
  - rise -> onTime<=hiLatch, offTime<=cnt, capValid<=1 for one cycle, cnt<=1, go HIGH.
  - cnt==STUCK_CYC with no rise -> STUCK, stuckLo<=1.
- STUCK:
  - rise -> HIGH, cnt<=1, both stuck flags cleared.
  - fall -> IDLE, cnt<=0, flags cleared.
  - onTime/offTime keep their last values.
- Counting rule: with pwmS high for exactly H cycles, the captured value is exactly H; the same applies to L low cycles. No off-by-one allowed.
- Simultaneous events: an edge in the same cycle that cnt==STUCK_CYC wins, so no stuck flag is raised. en=0 beats everything.
- capValid:
  - registered; high the cycle after the rise detection.
  - onTime/offTime are already updated and stable in that cycle.
  - never asserted for a period whose high phase was not fully observed.
- Reset mid-operation: all outputs drop to reset values asynchronously. The first capture after release needs a full rise-fall-rise.

Optional Feature:
MOTORO3_PWM_CAP_DEGLITCH_EN:
- Defined: a filter stage follows pwmS. Filtered level pwmF changes only after pwmS differs from pwmF for DGL_N consecutive cycles, and edges are derived from pwmF.
  - Adds DGL_N cycles of latency, equal on both edges, so durations of pulses >= DGL_N are preserved.
  - Pulses shorter than DGL_N are suppressed entirely.
- Undefined: edges come directly from pwmS; no filter logic is generated.

Test Plan:
- Steady PWM, en: aE=1; pwmIn 272 cycles high / 239 cycles low, 5 periods -> capValid 4 times (first rise only arms the block), each with onTime=0x110, offTime=0x0EF; stuck flags stay 0.
- Stuck: after one rise, hold pwmIn high 10000 cycles -> stuckHi=1 exactly 8000 cycles after the rise detection, no capValid; then drive low -> stuckHi=0 one cycle after fall detection, state IDLE.
- Disable mid-period: {aE,bE,cE}=000 during HIGH -> next cycle all outputs 0, no capValid. Re-enable with pwmIn already low -> no capValid until a rise, full high, full low, next rise.
- Falling edge first: enable with pwmIn high, then 100 high / 50 low pattern -> the first fall is ignored; first capValid has onTime=100, offTime=50.
- Async reset: assert nRst low during LOW state -> onTime/offTime/capValid/stuck flags 0 without a clock edge; after release, behaves as from power-up.
- Deglitch: 2-cycle high pulse within a low phase, DGL_N=4 -> macro defined: no extra capture, offTime includes the pulse span; macro undefined: capValid with onTime=2.

Source files
------------

// File: rtl/motoro3_pwm_capture.sv
// PWM capture: measures the high/low durations of pwmIn in clk cycles and flags a stuck input.
// Optional input deglitch filter is built when MOTORO3_PWM_CAP_DEGLITCH_EN is defined.
module motoro3_pwm_capture #(
    parameter int unsigned      CNT_W     = 13,
    parameter logic [CNT_W-1:0] STUCK_CYC = 13'd8000,
    parameter int unsigned      DGL_N     = 4
) (
    input  logic             clk,
    input  logic             nRst,
    input  logic             pwmIn,
    input  logic             aE,
    input  logic             bE,
    input  logic             cE,
    output logic [CNT_W-1:0] onTime,
    output logic [CNT_W-1:0] offTime,
    output logic             capValid,
    output logic             stuckHi,
    output logic             stuckLo
);
    typedef enum logic [1:0] {IDLE, HIGH, LOW, STUCK} state_t;

    state_t           state_q, state_d;
    logic [1:0]       sync_q;
    logic             pwm_s;
    logic             lvl;
    logic             lvl_d_q;
    logic             rise, fall, en;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] hi_latch_q, hi_latch_d;
    logic [CNT_W-1:0] on_time_q, on_time_d;
    logic [CNT_W-1:0] off_time_q, off_time_d;
    logic             cap_valid_q, cap_valid_d;
    logic             stuck_hi_q, stuck_hi_d;
    logic             stuck_lo_q, stuck_lo_d;

    assign pwm_s = sync_q[1];

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            sync_q  <= '0;
            lvl_d_q <= 1'b0;
        end else begin
            sync_q  <= {sync_q[0], pwmIn};
            lvl_d_q <= lvl;
        end
    end

`ifdef MOTORO3_PWM_CAP_DEGLITCH_EN
    localparam int unsigned DGL_W = (DGL_N > 1) ? $clog2(DGL_N) : 1;

    logic             pwm_f_q, pwm_f_d;
    logic [DGL_W-1:0] dgl_q, dgl_d;

    // The filtered level flips on the DGL_N-th consecutive cycle of disagreement.
    always_comb begin
        pwm_f_d = pwm_f_q;
        dgl_d   = '0;
        if (pwm_s != pwm_f_q) begin
            if (dgl_q == DGL_W'(DGL_N - 1)) begin
                pwm_f_d = pwm_s;
            end else begin
                dgl_d = dgl_q + DGL_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            pwm_f_q <= 1'b0;
            dgl_q   <= '0;
        end else begin
            pwm_f_q <= pwm_f_d;
            dgl_q   <= dgl_d;
        end
    end

    assign lvl = pwm_f_q;
`else
    assign lvl = pwm_s;
`endif

    assign rise = lvl & ~lvl_d_q;
    assign fall = ~lvl & lvl_d_q;
    assign en   = aE | bE | cE;

    // Edges are checked before the stuck limit so an edge on the limit cycle wins.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        hi_latch_d  = hi_latch_q;
        on_time_d   = on_time_q;
        off_time_d  = off_time_q;
        cap_valid_d = 1'b0;
        stuck_hi_d  = stuck_hi_q;
        stuck_lo_d  = stuck_lo_q;
        if (!en) begin
            state_d    = IDLE;
            cnt_d      = '0;
            on_time_d  = '0;
            off_time_d = '0;
            stuck_hi_d = 1'b0;
            stuck_lo_d = 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (rise) begin
                        state_d = HIGH;
                        cnt_d   = CNT_W'(1);
                    end else if (cnt_q == STUCK_CYC) begin
                        state_d    = STUCK;
                        stuck_hi_d = lvl;
                        stuck_lo_d = ~lvl;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                HIGH: begin
                    if (fall) begin
                        state_d    = LOW;
                        hi_latch_d = cnt_q;
                        cnt_d      = CNT_W'(1);
                    end else if (cnt_q == STUCK_CYC) begin
                        state_d    = STUCK;
                        stuck_hi_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                LOW: begin
                    if (rise) begin
                        state_d     = HIGH;
                        on_time_d   = hi_latch_q;
                        off_time_d  = cnt_q;
                        cap_valid_d = 1'b1;
                        cnt_d       = CNT_W'(1);
                    end else if (cnt_q == STUCK_CYC) begin
                        state_d    = STUCK;
                        stuck_lo_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                STUCK: begin
                    if (rise) begin
                        state_d    = HIGH;
                        cnt_d      = CNT_W'(1);
                        stuck_hi_d = 1'b0;
                        stuck_lo_d = 1'b0;
                    end else if (fall) begin
                        state_d    = IDLE;
                        cnt_d      = '0;
                        stuck_hi_d = 1'b0;
                        stuck_lo_d = 1'b0;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            hi_latch_q  <= '0;
            on_time_q   <= '0;
            off_time_q  <= '0;
            cap_valid_q <= 1'b0;
            stuck_hi_q  <= 1'b0;
            stuck_lo_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            hi_latch_q  <= hi_latch_d;
            on_time_q   <= on_time_d;
            off_time_q  <= off_time_d;
            cap_valid_q <= cap_valid_d;
            stuck_hi_q  <= stuck_hi_d;
            stuck_lo_q  <= stuck_lo_d;
        end
    end

    assign onTime   = on_time_q;
    assign offTime  = off_time_q;
    assign capValid = cap_valid_q;
    assign stuckHi  = stuck_hi_q;
    assign stuckLo  = stuck_lo_q;

endmodule

// File: tb/tb_motoro3_pwm_capture.sv
// Bench for motoro3_pwm_capture: directed scenarios plus randomized segments checked each cycle
// against a run-length reference model of the synchronised (optionally filtered) input.
module tb_motoro3_pwm_capture;
    localparam int CNT_W = 13;
    localparam int STUCK = 8000;
    localparam int DGL   = 4;
`ifdef MOTORO3_PWM_CAP_DEGLITCH_EN
    localparam bit DGL_ON = 1'b1;
`else
    localparam bit DGL_ON = 1'b0;
`endif
    localparam int LAT_X = DGL_ON ? DGL : 0;

    logic             clk = 1'b0;
    logic             nRst;
    logic             pwmIn;
    logic             aE, bE, cE;
    logic [CNT_W-1:0] onTime, offTime;
    logic             capValid, stuckHi, stuckLo;

    motoro3_pwm_capture #(
        .CNT_W    (CNT_W),
        .STUCK_CYC(13'd8000),
        .DGL_N    (DGL)
    ) dut (
        .clk     (clk),
        .nRst    (nRst),
        .pwmIn   (pwmIn),
        .aE      (aE),
        .bE      (bE),
        .cE      (cE),
        .onTime  (onTime),
        .offTime (offTime),
        .capValid(capValid),
        .stuckHi (stuckHi),
        .stuckLo (stuckLo)
    );

    always #50 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int cap_seen = 0;
    int last_on = 0, last_off = 0;
    int shi_rise_cyc = -1;
    bit shi_prev = 1'b0;
    bit stuck_seen = 1'b0;

    // Reference model: input pipeline, run measurement and expected outputs.
    bit m_s1, m_s, m_f, m_lvl_prev;
    bit m_win[$];
    bit m_ref, m_locked;
    int m_age, m_hi_len;
    int e_on, e_off;
    bit e_cap, e_shi, e_slo;

    task automatic check_val(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s got=%0d expected=%0d cycle=%0d", tag, got, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_s1 = 0; m_s = 0; m_f = 0; m_lvl_prev = 0;
        m_win.delete();
        for (int i = 0; i < DGL; i++) m_win.push_back(1'b0);
        m_ref = 0; m_locked = 0; m_age = 0; m_hi_len = 0;
        e_on = 0; e_off = 0; e_cap = 0; e_shi = 0; e_slo = 0;
    endtask

    task automatic model_edge();
        bit lv, rise, fall, en, all_diff;
        if (!nRst) begin
            model_reset();
        end else begin
            lv   = DGL_ON ? m_f : m_s;
            rise = lv && !m_lvl_prev;
            fall = !lv && m_lvl_prev;
            en   = aE | bE | cE;
            e_cap = 1'b0;
            if (!en) begin
                e_on = 0; e_off = 0; e_shi = 0; e_slo = 0;
                m_ref = 0; m_locked = 0; m_age = 0;
            end else if (m_locked) begin
                if (rise) begin
                    m_locked = 0; e_shi = 0; e_slo = 0; m_ref = 1; m_age = 1;
                end else if (fall) begin
                    m_locked = 0; e_shi = 0; e_slo = 0; m_ref = 0; m_age = 0;
                end
            end else if (!m_ref) begin
                if (rise) begin
                    m_ref = 1; m_age = 1;
                end else if (m_age == STUCK) begin
                    m_locked = 1; e_shi = lv; e_slo = !lv;
                end else m_age++;
            end else if (m_lvl_prev) begin
                // measuring a high run
                if (fall) begin
                    m_hi_len = m_age; m_age = 1;
                end else if (m_age == STUCK) begin
                    m_locked = 1; e_shi = 1;
                end else m_age++;
            end else begin
                if (rise) begin
                    e_on = m_hi_len; e_off = m_age; e_cap = 1; m_age = 1;
                end else if (m_age == STUCK) begin
                    m_locked = 1; e_slo = 1;
                end else m_age++;
            end
            all_diff = 1'b1;
            foreach (m_win[i]) if (m_win[i] == m_f) all_diff = 1'b0;
            if (all_diff) m_f = m_s;
            m_lvl_prev = lv;
            m_s  = m_s1;
            m_s1 = pwmIn;
            m_win.push_back(m_s);
            void'(m_win.pop_front());
        end
    endtask

    task automatic step();
        @(posedge clk);
        cyc++;
        model_edge();
        #1;
        check_val("capValid", int'(capValid), int'(e_cap));
        check_val("onTime", int'(onTime), e_on);
        check_val("offTime", int'(offTime), e_off);
        check_val("stuckHi", int'(stuckHi), int'(e_shi));
        check_val("stuckLo", int'(stuckLo), int'(e_slo));
        if (capValid) begin
            cap_seen++;
            last_on  = int'(onTime);
            last_off = int'(offTime);
            $display("cycle %0d capture onTime=%0d offTime=%0d", cyc, last_on, last_off);
        end
        if (stuckHi && !shi_prev) shi_rise_cyc = cyc;
        shi_prev = stuckHi;
        if (stuckHi || stuckLo) stuck_seen = 1'b1;
    endtask

    task automatic seg(input bit lvl, input int n);
        pwmIn = lvl;
        repeat (n) step();
    endtask

    task automatic gap(input logic [2:0] bits);
        {aE, bE, cE} = 3'b000;
        repeat (3) step();
        {aE, bE, cE} = bits;
    endtask

    task automatic do_async_reset();
        #20;
        nRst = 1'b0;
        model_reset();
        #1;
        check_val("arst_onTime", int'(onTime), 0);
        check_val("arst_offTime", int'(offTime), 0);
        check_val("arst_capValid", int'(capValid), 0);
        check_val("arst_stuckHi", int'(stuckHi), 0);
        check_val("arst_stuckLo", int'(stuckLo), 0);
        step();
        step();
        nRst = 1'b1;
    endtask

    int base, rise_cyc, kind;

    initial begin
        nRst = 1'b0; pwmIn = 1'b0; {aE, bE, cE} = 3'b000;
        model_reset();
        repeat (3) step();
        nRst = 1'b1;

        // steady PWM 272/239, five periods
        {aE, bE, cE} = 3'b100;
        seg(0, 20);
        base = cap_seen;
        for (int p = 0; p < 5; p++) begin
            seg(1, 272);
            seg(0, 239);
        end
        check_val("steady_caps", cap_seen - base, 4);
        check_val("steady_on", last_on, 272);
        check_val("steady_off", last_off, 239);

        // stuck high after one rise
        gap(3'b100);
        seg(0, 30);
        base = cap_seen;
        shi_rise_cyc = -1;
        rise_cyc = cyc + 1;
        seg(1, 10000);
        check_val("stuck_lat", shi_rise_cyc - rise_cyc, 8002 + LAT_X);
        check_val("stuck_hi_set", int'(stuckHi), 1);
        seg(0, 20);
        check_val("stuck_hi_clr", int'(stuckHi), 0);
        check_val("stuck_caps", cap_seen - base, 0);

        // disable mid-period, re-enable with input low
        gap(3'b010);
        seg(0, 30); seg(1, 50); seg(0, 40); seg(1, 30);
        check_val("dis_pre_on", last_on, 50);
        base = cap_seen;
        {aE, bE, cE} = 3'b000;
        step();
        check_val("dis_onTime", int'(onTime), 0);
        check_val("dis_offTime", int'(offTime), 0);
        seg(0, 5);
        {aE, bE, cE} = 3'b001;
        seg(0, 60); seg(1, 70); seg(0, 80);
        check_val("dis_nocap", cap_seen - base, 0);
        seg(1, 40);
        check_val("dis_caps", cap_seen - base, 1);
        check_val("dis_on", last_on, 70);
        check_val("dis_off", last_off, 80);

        // enable while high: first fall ignored
        {aE, bE, cE} = 3'b000;
        seg(1, 5);
        {aE, bE, cE} = 3'b010;
        base = cap_seen;
        seg(1, 100); seg(0, 50); seg(1, 100); seg(0, 50); seg(1, 10);
        check_val("ff_caps", cap_seen - base, 1);
        check_val("ff_on", last_on, 100);
        check_val("ff_off", last_off, 50);

        // asynchronous reset in LOW
        seg(1, 60); seg(0, 20);
        do_async_reset();
        base = cap_seen;
        seg(0, 10); seg(1, 40); seg(0, 30); seg(1, 12);
        check_val("rst_caps", cap_seen - base, 1);
        check_val("rst_on", last_on, 40);
        check_val("rst_off", last_off, 30);

        // 2-cycle glitch inside a low phase
        gap(3'b001);
        base = cap_seen;
        seg(0, 20); seg(1, 50); seg(0, 30); seg(1, 2); seg(0, 40); seg(1, 12);
        check_val("dgl_caps", cap_seen - base, DGL_ON ? 1 : 2);
        check_val("dgl_on", last_on, DGL_ON ? 50 : 2);
        check_val("dgl_off", last_off, DGL_ON ? 72 : 40);

        // edges exactly on the stuck limit win
        gap(3'b100);
        base = cap_seen;
        stuck_seen = 1'b0;
        seg(0, 20); seg(1, STUCK); seg(0, STUCK); seg(1, 12);
        check_val("bnd_caps", cap_seen - base, 1);
        check_val("bnd_on", last_on, STUCK);
        check_val("bnd_off", last_off, STUCK);
        check_val("bnd_nostuck", int'(stuck_seen), 0);

        // randomized segments
        for (int k = 0; k < 40; k++) begin
            kind = $urandom_range(0, 19);
            if (kind == 0) begin
                seg(1'($urandom_range(0, 1)), $urandom_range(7990, 8300));
            end else if (kind == 1) begin
                {aE, bE, cE} = 3'b000;
                repeat ($urandom_range(1, 4)) step();
                {aE, bE, cE} = 3'($urandom_range(1, 7));
            end else if (kind == 2) begin
                seg(~pwmIn, $urandom_range(1, 6));
            end else if (kind == 3) begin
                do_async_reset();
            end else begin
                seg(~pwmIn, $urandom_range(1, 300));
            end
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
